// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the serial read-out port: FSM states and default datapath width.
// The optional parity bit is controlled by the SERIALIZER_PARITY_EN macro in the top level.
package reg_serializer_pkg;

   localparam int DEFAULT_WIDTH = 64;
   localparam int STATE_W       = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/reg_serializer_bit_counter.sv
// Down-counter with synchronous load and a zero flag; it holds at zero rather than wrapping.
module reg_serializer_bit_counter #(
   parameter int W = 6
) (
   input  logic         clock,
   input  logic         R,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (R) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial read-out port: load/ready handshake, one bit per clock with a valid strobe.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
import reg_serializer_pkg::*;

module reg_serializer #(
   parameter int N         = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic         clock,
   input  logic         R,
   input  logic [N-1:0] D,
   input  logic         L,
   output logic         ready,
   output logic         sout,
   output logic         sval,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LOAD_VAL = CW'(N - 1);

   state_t       state_q, state_d;
   logic [N-1:0] sreg_q, sreg_d;
   logic         ready_q, ready_d;
   logic         sout_q, sout_d;
   logic         sval_q, sval_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         cnt_load;
   logic         cnt_dec;
   logic         cnt_zero;
`ifdef SERIALIZER_PARITY_EN
   logic         parity_q, parity_d;
`endif

   reg_serializer_bit_counter #(
      .W (CW)
   ) u_bit_counter (
      .clock    (clock),
      .R        (R),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Outputs are computed one cycle ahead so they leave the block straight from flops;
   // sout_d is therefore the output-end bit of the next shift register value.
   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      ready_d  = 1'b0;
      sout_d   = 1'b0;
      sval_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (L) begin
               state_d  = SHIFT;
               sreg_d   = D;
               cnt_load = 1'b1;
               sval_d   = 1'b1;
               busy_d   = 1'b1;
               sout_d   = LSB_FIRST ? D[0] : D[N-1];
`ifdef SERIALIZER_PARITY_EN
               parity_d = ^D;
`endif
            end else begin
               ready_d = 1'b1;
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            if (cnt_zero) begin
`ifdef SERIALIZER_PARITY_EN
               state_d = PARITY;
               sval_d  = 1'b1;
               sout_d  = parity_q;
`else
               state_d = DONE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_dec = 1'b1;
               sreg_d  = LSB_FIRST ? {1'b0, sreg_q[N-1:1]} : {sreg_q[N-2:0], 1'b0};
               sval_d  = 1'b1;
               sout_d  = LSB_FIRST ? sreg_q[1] : sreg_q[N-2];
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            state_d = DONE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
         end
`endif
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (R) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         ready_q  <= 1'b1;
         sout_q   <= 1'b0;
         sval_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         ready_q  <= ready_d;
         sout_q   <= sout_d;
         sval_q   <= sval_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign ready = ready_q;
   assign sout  = sout_q;
   assign sval  = sval_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: an MSB-first and an LSB-first instance share stimulus and are
// checked every cycle against a queue-based model of the expected per-cycle outputs.
module tb_reg_serializer;

   localparam int N = 8;

   logic         clock = 1'b0;
   logic         R = 1'b1;
   logic         L = 1'b0;
   logic [N-1:0] D = '0;

   logic ready_m, sout_m, sval_m, busy_m, done_m;
   logic ready_l, sout_l, sval_l, busy_l, done_l;

   int compared   = 0;
   int mismatched = 0;
   bit checking   = 1'b0;

   typedef struct {
      int kind;
      int idx;
   } ent_t;

   localparam int K_DATA   = 0;
   localparam int K_PARITY = 1;
   localparam int K_DONE   = 2;

   ent_t         exp_q[$];
   logic [N-1:0] cur_word = '0;

`ifdef SERIALIZER_PARITY_EN
   logic last_par_m, last_par_l;
`endif

   reg_serializer #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
      .clock (clock), .R (R), .D (D), .L (L),
      .ready (ready_m), .sout (sout_m), .sval (sval_m), .busy (busy_m), .done (done_m)
   );

   reg_serializer #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
      .clock (clock), .R (R), .D (D), .L (L),
      .ready (ready_l), .sout (sout_l), .sval (sval_l), .busy (busy_l), .done (done_l)
   );

   always #5 clock = ~clock;

   // The queue front describes the current cycle; an empty queue means the port is idle.
   always @(posedge clock) begin
      if (R) begin
         exp_q.delete();
      end else if (exp_q.size() == 0) begin
         if (L) begin
            cur_word = D;
            for (int i = 0; i < N; i++) exp_q.push_back('{K_DATA, i});
`ifdef SERIALIZER_PARITY_EN
            exp_q.push_back('{K_PARITY, 0});
`endif
            exp_q.push_back('{K_DONE, 0});
         end
      end else begin
         void'(exp_q.pop_front());
      end
   end

   task automatic checkOutput(input string name, input logic act, input logic expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
      end
   endtask

   task automatic checkWord(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic [N-1:0] d);
      @(posedge clock);
      #1;
      R = r;
      L = l;
      D = d;
   endtask

   always @(negedge clock) begin
      if (checking) begin
         logic e_rdy, e_sm, e_sl, e_val, e_busy, e_done;
         e_rdy = 1'b0; e_sm = 1'b0; e_sl = 1'b0; e_val = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         if (exp_q.size() == 0) begin
            e_rdy = 1'b1;
         end else if (exp_q[0].kind == K_DATA) begin
            e_val = 1'b1; e_busy = 1'b1;
            e_sm  = cur_word[N-1-exp_q[0].idx];
            e_sl  = cur_word[exp_q[0].idx];
         end else if (exp_q[0].kind == K_PARITY) begin
            e_val = 1'b1; e_busy = 1'b1;
            e_sm  = ^cur_word;
            e_sl  = ^cur_word;
         end else begin
            e_done = 1'b1; e_busy = 1'b1;
         end
         checkOutput("msb_ready", ready_m, e_rdy);
         checkOutput("msb_sout",  sout_m,  e_sm);
         checkOutput("msb_sval",  sval_m,  e_val);
         checkOutput("msb_busy",  busy_m,  e_busy);
         checkOutput("msb_done",  done_m,  e_done);
         checkOutput("lsb_ready", ready_l, e_rdy);
         checkOutput("lsb_sout",  sout_l,  e_sl);
         checkOutput("lsb_sval",  sval_l,  e_val);
         checkOutput("lsb_busy",  busy_l,  e_busy);
         checkOutput("lsb_done",  done_l,  e_done);
      end
   end

   // Pulses L for one accept, then collects the serial bits and checks the done/ready timing.
   task automatic runWord(input logic [N-1:0] d);
      logic [N-1:0] mw, lw;
      mw = '0;
      lw = '0;
      applyStimulus(1'b0, 1'b1, d);
      applyStimulus(1'b0, 1'b0, '0);
      for (int i = 0; i < N; i++) begin
         @(negedge clock);
         mw[N-1-i] = sout_m;
         lw[i]     = sout_l;
      end
`ifdef SERIALIZER_PARITY_EN
      @(negedge clock);
      last_par_m = sout_m;
      last_par_l = sout_l;
`endif
      @(negedge clock);
      checkOutput("done_pulse_msb", done_m, 1'b1);
      checkOutput("done_pulse_lsb", done_l, 1'b1);
      @(negedge clock);
      checkOutput("ready_after_done", ready_m, 1'b1);
      checkOutput("done_cleared", done_m, 1'b0);
      checkWord("word_msb_first", mw, d);
      checkWord("word_lsb_first", lw, d);
   endtask

   initial begin
      logic any_one;
      repeat (2) @(posedge clock);
      #1;
      R = 1'b0;
      checking = 1'b1;
      @(negedge clock);
      checkOutput("reset_ready", ready_m, 1'b1);
      checkOutput("reset_sval",  sval_m,  1'b0);
      checkOutput("reset_sout",  sout_m,  1'b0);
      checkOutput("reset_busy",  busy_m,  1'b0);
      checkOutput("reset_done",  done_m,  1'b0);

      runWord(8'hA5);
`ifdef SERIALIZER_PARITY_EN
      checkOutput("parity_a5", last_par_m, 1'b0);
      checkOutput("parity_a5_lsb", last_par_l, 1'b0);
`endif
      runWord(8'h07);
`ifdef SERIALIZER_PARITY_EN
      checkOutput("parity_07", last_par_m, 1'b1);
      checkOutput("parity_07_lsb", last_par_l, 1'b1);
`endif

      // L held high with a new word while 0x00 is shifting out must not disturb it.
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'hFF);
      any_one = 1'b0;
      for (int i = 0; i < N; i++) begin
         @(negedge clock);
         any_one = any_one | sout_m | sout_l;
      end
      checkOutput("ignored_load_bits", any_one, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b0, '0);
      repeat (N + 6) applyStimulus(1'b0, 1'b0, '0);

      // Reset asserted in the fourth data cycle aborts the transfer without done.
      applyStimulus(1'b0, 1'b1, 8'h3C);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      @(negedge clock);
      checkOutput("abort_ready", ready_m, 1'b1);
      checkOutput("abort_sval",  sval_m,  1'b0);
      checkOutput("abort_done",  done_m,  1'b0);
      checkOutput("abort_busy",  busy_l,  1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, '0);
      runWord(8'h5A);

      for (int c = 0; c < 800; c++) begin
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0, N'($urandom));
      end
      repeat (N + 6) applyStimulus(1'b0, 1'b0, '0);
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/reg_serializer.md
# reg_serializer

Parallel-to-serial read-out port for an N-bit datapath word. Accepts a word through a load/ready handshake and shifts it out one bit per clock with a per-bit valid strobe. Pulses completion after the last bit. Sits behind the N-bit datapath registers as their serial read-side counterpart, e.g. for debug/scan read-out or a serial link transmitter.

## Interface
- N, 64, word width in bits; legal range N ≥ 2
- LSB_FIRST, 0, bit order: 0 = MSB first, 1 = LSB first
- clock  in  1  positive-edge clock
- R  in  1  reset, synchronous and active-high
- D  in  N  parallel data word to transmit
- L  in  1  load request; the word is accepted on a rising clock edge where L=1 and ready=1
- ready  out  1  high only in IDLE; the block can accept a word
- sout  out  1  serial data bit
- sval  out  1  high during every cycle sout carries a valid bit
- busy  out  1  high in SHIFT, PARITY and DONE
- done  out  1  one-cycle pulse after the final bit

## Operation
- States: IDLE, SHIFT, PARITY (present only with the macro), DONE.
- IDLE:
  - ready=1, sval=0, sout=0, busy=0.
  - On L=1: capture D into the shift register, load the bit counter with N-1, compute the parity of D if the macro is enabled, then go to SHIFT.
- SHIFT:
  - sval=1.
  - sout = sreg[N-1] when LSB_FIRST=0, otherwise sreg[0].
  - Each cycle: shift toward the output end with zero fill, and decrement the counter.
  - When counter==0: go to PARITY (macro on) or DONE (macro off).
- PARITY: sval=1, sout=captured parity bit; then go to DONE.
- DONE: done=1, sval=0, sout=0; then go to IDLE.
- L is ignored whenever ready=0. There is no queueing, and D changes after capture have no effect.
- R has priority over L and over all state activity.
  - Reset mid-transfer aborts the transfer immediately with no done pulse.
  - The next cycle is IDLE.
- Reset values, after the reset edge: state=IDLE, ready=1, sval=0, sout=0, busy=0, done=0, shift register=0, counter=0.
- Counter width is $clog2(N). There is no wrap-around; the counter is reloaded only on an accept.
- All outputs decode from registered state. There are no combinational paths from D or L to any output.

## Timing
- Accept edge at cycle k. Data bits are presented in cycles k+1 … k+N.
- With the macro on, the parity bit is presented in cycle k+N+1.
- done is high in cycle k+N+1 (macro off) or k+N+2 (macro on).
- ready rises the cycle after done, so back-to-back transfers have a 2-cycle gap (DONE plus the accept cycle).
- Throughput is one word per N+2 cycles (N+3 with parity).
- L held continuously high restarts on the first cycle ready=1.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - The PARITY state is compiled in.
  - One extra bit is sent after the data: even parity, equal to the XOR of all N captured bits, with sval=1.
  - All done/ready timing shifts by +1 cycle.
- SERIALIZER_PARITY_EN undefined: the PARITY state and the parity register are absent, and SHIFT goes directly to DONE.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, PARITY, DONE)
  - a state-width constant
  - the default-width constant (64), shared with the other datapath registers
- Sub-module: bit_counter
  - Down-counter with synchronous load and a zero flag, parameterized by width.
  - Shift register and FSM stay in the top level.

## Test plan
- Reset: R=1 for 2 cycles, then R=0.
  - Response: ready=1, sval=0, sout=0, busy=0, done=0.
- N=8, LSB_FIRST=0, D=0xA5, L pulsed at k.
  - Response: sout=1,0,1,0,0,1,0,1 in cycles k+1..k+8, sval=1 in those cycles, done=1 at k+9, ready=1 at k+10.
- N=8, LSB_FIRST=1, D=0xA5.
  - Response: sout=1,0,1,0,0,1,0,1 (LSB first), with the same strobe timing as above.
- SERIALIZER_PARITY_EN, N=8.
  - D=0xA5: 8 data bits, then parity bit 0; done at k+10.
  - D=0x07: parity bit 1.
- L=1 with D=0xFF during SHIFT of word 0x00: the request is ignored, all 8 bits are 0, and no second transfer starts until ready=1.
- R=1 at cycle k+4 of a transfer.
  - Response: next cycle IDLE, sval=0, no done pulse; a new word loads correctly afterward.
